// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage register hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned RW   = 5;

  localparam logic STG_E = 1'b0;
  localparam logic STG_M = 1'b1;

  typedef struct packed {
    logic valid;
    logic stage;
    logic load;
  } entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue-point and decode-stage signals between the pipeline control path and the scoreboard.
interface hazard_scoreboard_if #(
  parameter int unsigned NREG = 32,
  parameter int unsigned RW   = 5
) ();

  logic            issue_en;
  logic            issue_regwrite;
  logic            issue_memtoreg;
  logic [RW-1:0]   issue_writereg;
  logic            flushE;
  logic [RW-1:0]   rsD;
  logic [RW-1:0]   rtD;
  logic            usesrsD;
  logic            usesrtD;
  logic            branchD;
  logic            stallD;
  logic [NREG-1:0] busy;

  modport master (
    output issue_en, issue_regwrite, issue_memtoreg, issue_writereg, flushE,
    output rsD, rtD, usesrsD, usesrtD, branchD,
    input  stallD, busy
  );

  modport slave (
    input  issue_en, issue_regwrite, issue_memtoreg, issue_writereg, flushE,
    input  rsD, rtD, usesrsD, usesrtD, branchD,
    output stallD, busy
  );

endinterface

// File: rtl/scoreboard_entry.sv
// Pending-write tracker for one architectural register: issue into E, age E->M->retired.
module scoreboard_entry
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   issue,
  input  logic   load,
  input  logic   flush,
  output entry_t entry
);

  entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (issue) begin
      // Newest writer wins, even over an entry retiring from M on this edge.
      entry_d = '{valid: 1'b1, stage: STG_E, load: load};
    end else if (entry_q.valid) begin
      if (entry_q.stage == STG_E && !flush) begin
        entry_d.stage = STG_M;
      end else begin
        entry_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry = entry_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight E/M register writes and stalls decode on hazards forwarding cannot cover.
module hazard_scoreboard #(
  parameter int unsigned NREG = hazard_pkg::NREG,
  parameter int unsigned RW   = hazard_pkg::RW
) (
  input logic               clk,
  input logic               reset,
  hazard_scoreboard_if.slave sb
);
  import hazard_pkg::*;

  entry_t          ent [NREG];
  logic            issue_fire;
  logic [NREG-1:0] busy_vec;
  logic            stall_rs;
  logic            stall_rt;

  assign issue_fire = sb.issue_en & sb.issue_regwrite & ~sb.flushE &
                      (sb.issue_writereg != '0);

  assign ent[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    scoreboard_entry u_entry (
      .clk   (clk),
      .reset (reset),
      .issue (issue_fire && (sb.issue_writereg == RW'(r))),
      .load  (sb.issue_memtoreg),
      .flush (sb.flushE),
      .entry (ent[r])
    );
  end

  always_comb begin
    busy_vec = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      busy_vec[r] = ent[r].valid;
    end
  end

  // Branches compare in D and only see M-forwarded values, so they wait longer.
  function automatic logic src_stall(entry_t e, logic branch);
    return e.valid &&
           ((e.stage == STG_E && (e.load || branch)) ||
            (e.stage == STG_M && e.load && branch));
  endfunction

  always_comb begin
    stall_rs = sb.usesrsD && (sb.rsD != '0) && src_stall(ent[sb.rsD], sb.branchD);
    stall_rt = sb.usesrtD && (sb.rtD != '0) && src_stall(ent[sb.rtD], sb.branchD);
  end

  assign sb.stallD = stall_rs | stall_rt;
  assign sb.busy   = busy_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with an expected-value queue.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NREG(32), .RW(5)) sb_if ();

  hazard_scoreboard #(.NREG(32), .RW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  typedef struct {
    logic        en;
    logic        rw;
    logic        mem;
    logic [4:0]  wr;
    logic        fl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        urs;
    logic        urt;
    logic        br;
    logic        es;
    logic [31:0] eb;
  } vec_t;

  typedef struct {
    string       name;
    logic        stall;
    logic [31:0] busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always @(posedge clk) begin
    if (reset) begin
      assert (!(sb_if.issue_en && sb_if.stallD))
        else $error("issue_en and stallD both high");
    end
  end

  function automatic vec_t v(logic en, logic rw, logic mem, logic [4:0] wr, logic fl,
                             logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                             logic br, logic es, logic [31:0] eb);
    vec_t x;
    x = '{en, rw, mem, wr, fl, rs, rt, urs, urt, br, es, eb};
    return x;
  endfunction

  function automatic vec_t idle(logic [31:0] eb);
    return v(0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 0, 0, 0, 0, eb);
  endfunction

  task automatic drive_vec(input vec_t x, input string nm);
    exp_t e;
    sb_if.issue_en       = x.en;
    sb_if.issue_regwrite = x.rw;
    sb_if.issue_memtoreg = x.mem;
    sb_if.issue_writereg = x.wr;
    sb_if.flushE         = x.fl;
    sb_if.rsD            = x.rs;
    sb_if.rtD            = x.rt;
    sb_if.usesrsD        = x.urs;
    sb_if.usesrtD        = x.urt;
    sb_if.branchD        = x.br;
    e.name  = nm;
    e.stall = x.es;
    e.busy  = x.eb;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL queue_empty: no expected entry available");
      return;
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (sb_if.stallD !== e.stall) begin
      n_fail++;
      $display("FAIL %s stallD: got %0b expected %0b", e.name, sb_if.stallD, e.stall);
    end
    n_cmp++;
    if (sb_if.busy !== e.busy) begin
      n_fail++;
      $display("FAIL %s busy: got %08h expected %08h", e.name, sb_if.busy, e.busy);
    end
  endtask

  task automatic apply(input vec_t x, input string nm);
    @(negedge clk);
    drive_vec(x, nm);
    #1;
    check();
  endtask

  vec_t tbl [31];

  initial begin
    tbl[0]  = v(1, 1, 1, 5'd5,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // lw $5
    tbl[1]  = v(0, 0, 0, 5'd0,  0, 5'd5,  5'd0,  1, 0, 0, 1, 32'h20);    // add uses $5
    tbl[2]  = v(1, 1, 0, 5'd8,  0, 5'd5,  5'd0,  1, 0, 0, 0, 32'h20);    // add issues -> $8
    tbl[3]  = idle(32'h100);
    tbl[4]  = idle(32'h100);
    tbl[5]  = v(1, 1, 0, 5'd5,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // add $5
    tbl[6]  = v(0, 0, 0, 5'd0,  0, 5'd0,  5'd5,  0, 1, 1, 1, 32'h20);    // beq rt=5
    tbl[7]  = v(1, 0, 0, 5'd0,  0, 5'd0,  5'd5,  0, 1, 1, 0, 32'h20);
    tbl[8]  = v(1, 1, 1, 5'd5,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // lw $5
    tbl[9]  = v(0, 0, 0, 5'd0,  0, 5'd5,  5'd0,  1, 0, 1, 1, 32'h20);    // beq rs=5
    tbl[10] = v(0, 0, 0, 5'd0,  0, 5'd5,  5'd0,  1, 0, 1, 1, 32'h20);
    tbl[11] = v(1, 0, 0, 5'd0,  0, 5'd5,  5'd0,  1, 0, 1, 0, 32'h0);
    tbl[12] = v(1, 1, 1, 5'd0,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // lw $0
    tbl[13] = v(1, 1, 0, 5'd0,  0, 5'd0,  5'd0,  1, 0, 0, 0, 32'h0);
    tbl[14] = v(1, 1, 0, 5'd9,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // add $9
    tbl[15] = v(1, 1, 0, 5'd10, 0, 5'd9,  5'd9,  1, 1, 0, 0, 32'h200);   // ALU->ALU
    tbl[16] = idle(32'h600);
    tbl[17] = idle(32'h400);
    tbl[18] = v(1, 1, 1, 5'd7,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // lw $7
    tbl[19] = v(1, 1, 0, 5'd11, 1, 5'd0,  5'd0,  0, 0, 0, 0, 32'h80);    // flush, issue dropped
    tbl[20] = v(0, 0, 0, 5'd0,  0, 5'd7,  5'd7,  1, 0, 1, 0, 32'h0);
    tbl[21] = v(1, 1, 0, 5'd12, 0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);
    tbl[22] = v(0, 0, 0, 5'd0,  0, 5'd0,  5'd12, 0, 0, 1, 0, 32'h1000);  // unused rt
    tbl[23] = v(1, 1, 0, 5'd12, 0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h1000);  // reissue while retiring
    tbl[24] = v(0, 0, 0, 5'd0,  0, 5'd12, 5'd0,  1, 0, 1, 1, 32'h1000);
    tbl[25] = v(0, 0, 0, 5'd0,  0, 5'd12, 5'd0,  1, 0, 1, 0, 32'h1000);
    tbl[26] = v(1, 1, 1, 5'd3,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h0);     // lw $3
    tbl[27] = v(1, 1, 0, 5'd3,  0, 5'd0,  5'd0,  0, 0, 0, 0, 32'h8);     // add $3 overrides
    tbl[28] = v(0, 0, 0, 5'd0,  0, 5'd3,  5'd0,  1, 0, 0, 0, 32'h8);
    tbl[29] = idle(32'h8);
    tbl[30] = idle(32'h0);

    // Reset state: stalling-looking inputs must not stall while reset is held.
    drive_vec(v(1, 1, 1, 5'd5, 0, 5'd5, 5'd5, 1, 1, 1, 0, 32'h0), "in_reset");
    #12;
    check();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    drive_vec(idle(32'h0), "post_reset");
    #1;
    check();

    for (int i = 0; i < 31; i++) begin
      apply(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset in the middle of a cycle with a pending load.
    apply(v(1, 1, 1, 5'd3, 0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h0), "rst_pre0");
    apply(v(0, 0, 0, 5'd0, 0, 5'd3, 5'd0, 1, 0, 0, 1, 32'h8), "rst_pre1");
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back('{"rst_async", 1'b0, 32'h0});
    check();

    @(negedge clk);
    reset = 1'b1;
    drive_vec(v(1, 1, 1, 5'd4, 0, 5'd3, 5'd0, 1, 0, 1, 0, 32'h0), "rel0");
    #1;
    check();
    apply(v(0, 0, 0, 5'd0, 0, 5'd4, 5'd0, 1, 0, 0, 1, 32'h10), "rel1");
    apply(idle(32'h10), "rel2");
    apply(idle(32'h0), "rel3");

    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
